fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage, directly upstream of decodeUnit: holds PC, requests 32-bit words from instruction memory.
//  Buffers returned words with their PC and presents IR/NPC/PC + valid to decode.
//  Handles decode-side stalls and branch/jump redirects from EX, dropping wrong-path responses.
// PARAMETERS
//  NBITS     64          datapath / PC width
//  RESET_PC  'h400000    PC of first fetch after reset
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-low reset
//  stall_i        in   1      decode cannot accept this cycle
//  redirect_i     in   1      taken branch/jump from EX
//  redirect_pc_i  in   NBITS  redirect target; bits [1:0] ignored (forced 0)
//  imem_req_o     out  1      fetch request
//  imem_addr_o    out  NBITS  word address (bits [1:0] = 0)
//  imem_gnt_i     in   1      request accepted this cycle
//  imem_rvalid_i  in   1      response valid; in order, >=1 cycle after gnt
//  imem_rdata_i   in   32     instruction word
//  valid_o        out  1      IR_OUT/NPC_OUT/PC_OUT valid for decode
//  IR_OUT         out  32     instruction; 32'h00000013 (NOP) when !valid_o
//  NPC_OUT        out  NBITS  PC_OUT + 4
//  PC_OUT         out  NBITS  PC of IR_OUT
// BEHAVIOUR
//  Reset (rst=0): state=BOOT, pc=RESET_PC, outstanding=0, fifo empty, imem_req_o=0, valid_o=0,
//   IR_OUT=NOP, PC_OUT=0, NPC_OUT=4.
//  FSM: BOOT -> RUN after one cycle, no request in BOOT.
//   RUN: imem_req_o=1 when outstanding+fifo_count < 2.
//   RUN: redirect_i with outstanding(after this cycle's gnt/rvalid) > 0 -> FLUSH; otherwise stay RUN.
//   FLUSH: imem_req_o=0; every rvalid is discarded and decrements outstanding.
//   FLUSH: -> RUN in the cycle outstanding reaches 0; first new-path request issues the next cycle.
//  Request: imem_addr_o=pc. On gnt: pc<=pc+4 and outstanding++.
//   Request-side tag fifo records the PC of each granted request.
//  Response (RUN): {pc_tag, rdata} is pushed into the 2-entry fifo and outstanding--.
//   Credit rule guarantees the fifo never overflows; push when full is an assertion failure.
//  Output: head of fifo drives IR_OUT/PC_OUT, NPC_OUT=PC_OUT+4 (mod 2^NBITS).
//   valid_o = fifo not empty; combinational from fifo registers, zero added latency.
//   Pop when valid_o && !stall_i.
//   Push and pop in the same cycle are both allowed.
//   Empty-fifo bypass is not permitted: response-to-valid_o latency is exactly 1 cycle.
//  Redirect (priority over everything):
//   pc<=redirect_pc_i&~3 and fifo flushed (valid_o=0 next cycle).
//   No request in the redirect cycle, even if credits allow.
//   A gnt in the same cycle still counts as outstanding.
//   An rvalid in the same cycle is discarded.
//   A redirect while in FLUSH only reloads pc; the FSM stays in FLUSH.
//   stall_i during a redirect is ignored.
//  Wrap: pc+4 wraps at 2^NBITS without error.
//  Mid-op reset: all state is cleared immediately (async); in-flight memory responses after
//   reset release are not expected and are discarded while in BOOT.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   adds outputs perf_fetched_o[31:0] (++ on each pop) and perf_stall_o[31:0] (++ each cycle
//   valid_o && stall_i).
//   Both counters wrap, reset to 0, and are not cleared by redirect.
//  FETCH_PERF_CNT_EN undefined: ports and counters are absent.
// STRUCTURE
//  fetch_pkg: fetch_state_t enum {BOOT,RUN,FLUSH}, NOP_INSTR=32'h00000013, FETCH_DEPTH=2,
//   fetch_entry_t struct {pc, instr}.
//  Sub-module fetch_fifo: 2-entry sync fifo with flush, parameterised on entry type.
//   Used once for the response buffer and once for the pc tag queue.
//  Top level: FSM, pc register, outstanding counter (0..2), credit logic, output muxing.
// TESTING
//  1 rst low, release, gnt=1 always, rvalid 1 cycle after gnt, stall=0
//    -> first req addr 0x400000 on 2nd cycle after release.
//    -> valid_o with PC_OUT=0x400000, NPC_OUT=0x400004 one cycle after the rvalid carrying
//       IR 0xff010113.
//    -> one instruction per cycle thereafter.
//  2 stall_i=1 held 5 cycles
//    -> imem_req_o drops once outstanding+fifo=2.
//    -> IR_OUT/PC_OUT held constant.
//    -> after release, sequential PCs are delivered with no duplicates or gaps.
//  3 redirect_i with redirect_pc_i=0x400083 while 2 requests are outstanding
//    -> FLUSH, both responses dropped.
//    -> next req addr 0x400080.
//    -> first valid PC_OUT=0x400080.
//  4 redirect in the same cycle as gnt and rvalid
//    -> rvalid dropped, granted request also dropped.
//    -> no stale PC ever appears on valid_o.
//  5 gnt held low 4 cycles
//    -> imem_req_o and imem_addr_o held stable.
//    -> valid_o falls after the fifo drains.
//  6 rst asserted mid-stream (2 outstanding)
//    -> all outputs at reset values immediately.
//    -> restart from RESET_PC.
//  With FETCH_PERF_CNT_EN: scenario 2 gives perf_stall_o=5; perf_fetched_o equals the number
//   of pops.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int          PC_W        = 64;
   localparam int          FETCH_DEPTH = 2;
   localparam logic [31:0] NOP_INSTR   = 32'h00000013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous fifo with flush, parameterised on the stored entry type.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  entry_t     push_data,
   input  logic       pop,
   output entry_t     head,
   output logic       empty,
   output logic       full,
   output logic [1:0] count
);

   entry_t mem [FETCH_DEPTH];
   logic   rd_ptr;
   logic   wr_ptr;
   logic   pop_ok;

   assign pop_ok = pop && !empty;
   assign empty  = (count == 2'd0);
   assign full   = (count == 2'(FETCH_DEPTH));
   assign head   = mem[rd_ptr];

   // Flush drops every entry at once and wins over a same-cycle push or pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assert property (@(posedge clk) disable iff (!rst) !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, credit-limited imem requests, wrong-path response dropping and decode buffer.
// Define FETCH_PERF_CNT_EN to add the perf_fetched_o / perf_stall_o counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               NBITS    = PC_W,
   parameter logic [NBITS-1:0] RESET_PC = NBITS'('h400000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [NBITS-1:0] redirect_pc_i,
   output logic             imem_req_o,
   output logic [NBITS-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [31:0]      imem_rdata_i,
   output logic             valid_o,
   output logic [31:0]      IR_OUT,
   output logic [NBITS-1:0] NPC_OUT,
   output logic [NBITS-1:0] PC_OUT
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      perf_fetched_o,
   output logic [31:0]      perf_stall_o
`endif
);

   fetch_state_t     state_q;
   fetch_state_t     state_d;
   logic [NBITS-1:0] pc_q;
   logic [1:0]       outstanding_q;
   logic [1:0]       outstanding_d;
   logic [2:0]       occupancy;
   logic             pop_raw;
   logic             pop_fire;
   logic             credit_ok;
   logic             req_pre;
   logic             gnt_fire;
   logic             rvalid_fire;
   logic             resp_push;

   fetch_entry_t     resp_in;
   fetch_entry_t     resp_head;
   logic             resp_empty;
   logic             resp_full;
   logic [1:0]       resp_count;

   logic [NBITS-1:0] tag_head;
   logic             tag_empty;
   logic             tag_full;
   logic [1:0]       tag_count;

   assign valid_o  = !resp_empty;
   assign pop_raw  = valid_o && !stall_i;
   assign pop_fire = pop_raw && !redirect_i;

   // Credits count a same-cycle pop so a steady stream sustains one word per cycle.
   assign occupancy = {1'b0, outstanding_q} + {1'b0, resp_count} - {2'b00, pop_raw};
   assign credit_ok = (occupancy < 3'(FETCH_DEPTH));
   assign req_pre   = (state_q == RUN) && credit_ok;

   assign imem_req_o  = req_pre && !redirect_i;
   assign imem_addr_o = pc_q;

   // A grant seen in the redirect cycle is still a live request on the memory side.
   assign gnt_fire      = imem_gnt_i && req_pre;
   assign rvalid_fire   = imem_rvalid_i && (state_q != BOOT) && (outstanding_q != 2'd0);
   assign resp_push     = rvalid_fire && (state_q == RUN) && !redirect_i;
   assign outstanding_d = outstanding_q + {1'b0, gnt_fire} - {1'b0, rvalid_fire};

   assign resp_in.pc    = PC_W'(tag_head);
   assign resp_in.instr = imem_rdata_i;

   assign PC_OUT  = valid_o ? NBITS'(resp_head.pc) : '0;
   assign IR_OUT  = valid_o ? resp_head.instr : NOP_INSTR;
   assign NPC_OUT = PC_OUT + NBITS'(4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:  state_d = RUN;
         RUN: begin
            if (redirect_i && (outstanding_d != 2'd0)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (outstanding_d == 2'd0) begin
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= 2'd0;
      end else begin
         outstanding_q <= outstanding_d;
         if (redirect_i) begin
            pc_q <= redirect_pc_i & ~NBITS'(3);
         end else if (gnt_fire) begin
            pc_q <= pc_q + NBITS'(4);
         end
      end
   end

   fetch_fifo #(
      .entry_t (fetch_entry_t)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_i),
      .push      (resp_push),
      .push_data (resp_in),
      .pop       (pop_fire),
      .head      (resp_head),
      .empty     (resp_empty),
      .full      (resp_full),
      .count     (resp_count)
   );

   // Tags are never flushed: each one retires with its response, wanted or not.
   fetch_fifo #(
      .entry_t (logic [NBITS-1:0])
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (gnt_fire),
      .push_data (pc_q),
      .pop       (rvalid_fire),
      .head      (tag_head),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (tag_count)
   );

   assert property (@(posedge clk) disable iff (!rst)
      (tag_count == outstanding_q) && (tag_empty == (outstanding_q == 2'd0))
      && (tag_full == (outstanding_q == 2'd2)));
   assert property (@(posedge clk) disable iff (!rst) !(resp_full && (outstanding_q != 2'd0)));

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_o <= 32'd0;
         perf_stall_o   <= 32'd0;
      end else begin
         if (pop_fire) begin
            perf_fetched_o <= perf_fetched_o + 32'd1;
         end
         if (valid_o && stall_i) begin
            perf_stall_o <= perf_stall_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/stall, hand sequences for redirect, gnt gaps, reset and wrap.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [63:0] A0 = 64'h400000;

   typedef struct packed {
      logic        stall;
      logic        gnt;
      logic        rv;
      logic [63:0] raddr;
      logic        eReq;
      logic [63:0] eAddr;
      logic        eValid;
      logic [63:0] ePc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        valid_o;
   logic [31:0] IR_OUT;
   logic [63:0] NPC_OUT;
   logic [63:0] PC_OUT;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_stall_o;
`endif

   int   total = 0;
   int   bad = 0;
   vec_t vecs [14];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .valid_o       (valid_o),
      .IR_OUT        (IR_OUT),
      .NPC_OUT       (NPC_OUT),
      .PC_OUT        (PC_OUT)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o(perf_fetched_o),
      .perf_stall_o  (perf_stall_o)
`endif
   );

   function automatic logic [31:0] instrOf(input logic [63:0] a);
      if (a == 64'h400000) return 32'hff010113;
      return {a[31:2], 2'b11} ^ 32'h5a00_0000;
   endfunction

   function automatic vec_t mkVec(input logic stall, input logic gnt, input logic rv,
                                  input logic [63:0] raddr, input logic eReq,
                                  input logic [63:0] eAddr, input logic eValid,
                                  input logic [63:0] ePc);
      vec_t v;
      v.stall = stall; v.gnt = gnt; v.rv = rv; v.raddr = raddr;
      v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc;
      return v;
   endfunction

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic stall, input logic redir, input logic [63:0] rpc,
                                input logic gnt, input logic rv, input logic [63:0] raddr);
      stall_i       = stall;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? instrOf(raddr) : 32'hdeadbeef;
   endtask

   task automatic checkOutput(input string name, input logic eReq, input logic [63:0] eAddr,
                              input logic eValid, input logic [63:0] ePc);
      logic [63:0] pcExp;
      @(negedge clk);
      pcExp = eValid ? ePc : 64'd0;
      compare({name, ".req"}, 64'(imem_req_o), 64'(eReq));
      if (eReq) compare({name, ".addr"}, imem_addr_o, eAddr);
      compare({name, ".valid"}, 64'(valid_o), 64'(eValid));
      compare({name, ".ir"}, 64'(IR_OUT), 64'(eValid ? instrOf(ePc) : NOP_INSTR));
      compare({name, ".pc"}, PC_OUT, pcExp);
      compare({name, ".npc"}, NPC_OUT, pcExp + 64'd4);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string name, input logic stall, input logic redir, input logic [63:0] rpc,
                      input logic gnt, input logic rv, input logic [63:0] raddr, input logic eReq,
                      input logic [63:0] eAddr, input logic eValid, input logic [63:0] ePc);
      applyStimulus(stall, redir, rpc, gnt, rv, raddr);
      checkOutput(name, eReq, eAddr, eValid, ePc);
   endtask

   task automatic checkReset(input string name);
      compare({name, ".req"}, 64'(imem_req_o), 64'd0);
      compare({name, ".valid"}, 64'(valid_o), 64'd0);
      compare({name, ".ir"}, 64'(IR_OUT), 64'(NOP_INSTR));
      compare({name, ".pc"}, PC_OUT, 64'd0);
      compare({name, ".npc"}, NPC_OUT, 64'd4);
   endtask

   initial begin
      // Streaming start-up then a 5-cycle decode stall and its release.
      vecs[0]  = mkVec(0, 1, 0, 0,        0, 0,        0, 0);
      vecs[1]  = mkVec(0, 1, 0, 0,        1, A0,       0, 0);
      vecs[2]  = mkVec(0, 1, 1, A0,       1, A0 + 4,   0, 0);
      vecs[3]  = mkVec(0, 1, 1, A0 + 4,   1, A0 + 8,   1, A0);
      vecs[4]  = mkVec(0, 1, 1, A0 + 8,   1, A0 + 12,  1, A0 + 4);
      vecs[5]  = mkVec(1, 1, 1, A0 + 12,  0, 0,        1, A0 + 8);
      vecs[6]  = mkVec(1, 1, 0, 0,        0, 0,        1, A0 + 8);
      vecs[7]  = mkVec(1, 1, 0, 0,        0, 0,        1, A0 + 8);
      vecs[8]  = mkVec(1, 1, 0, 0,        0, 0,        1, A0 + 8);
      vecs[9]  = mkVec(1, 1, 0, 0,        0, 0,        1, A0 + 8);
      vecs[10] = mkVec(0, 1, 0, 0,        1, A0 + 16,  1, A0 + 8);
      vecs[11] = mkVec(0, 1, 1, A0 + 16,  1, A0 + 20,  1, A0 + 12);
      vecs[12] = mkVec(0, 1, 1, A0 + 20,  1, A0 + 24,  1, A0 + 16);
      vecs[13] = mkVec(0, 1, 1, A0 + 24,  1, A0 + 28,  1, A0 + 20);

      repeat (2) @(posedge clk);
      #1;
      checkReset("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].stall, 1'b0, 64'd0, vecs[i].gnt, vecs[i].rv, vecs[i].raddr);
         checkOutput($sformatf("stream[%0d]", i), vecs[i].eReq, vecs[i].eAddr,
                     vecs[i].eValid, vecs[i].ePc);
      end
`ifdef FETCH_PERF_CNT_EN
      compare("perf_stall", 64'(perf_stall_o), 64'd5);
      compare("perf_fetched", 64'(perf_fetched_o), 64'd6);
`endif

      // Redirect with two requests in flight: both responses must be dropped.
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc("rd0", 0, 0, 0,            1, 0, 0,            0, 0,            0, 0);
      cyc("rd1", 0, 0, 0,            1, 0, 0,            1, A0,           0, 0);
      cyc("rd2", 0, 0, 0,            1, 0, 0,            1, A0 + 4,       0, 0);
      cyc("rd3", 0, 1, 64'h400083,   1, 0, 0,            0, 0,            0, 0);
      cyc("rd4", 0, 0, 0,            1, 1, A0,           0, 0,            0, 0);
      cyc("rd5", 0, 0, 0,            1, 1, A0 + 4,       0, 0,            0, 0);
      cyc("rd6", 0, 0, 0,            1, 0, 0,            1, 64'h400080,   0, 0);
      cyc("rd7", 0, 0, 0,            1, 1, 64'h400080,   1, 64'h400084,   0, 0);
      cyc("rd8", 0, 0, 0,            1, 1, 64'h400084,   1, 64'h400088,   1, 64'h400080);

      // Redirect coinciding with a grant and a response.
      cyc("rg0", 0, 1, 64'h400200,   1, 1, 64'h400088,   0, 0,            1, 64'h400084);
      cyc("rg1", 0, 0, 0,            1, 1, 64'h40008c,   0, 0,            0, 0);
      cyc("rg2", 0, 0, 0,            1, 0, 0,            1, 64'h400200,   0, 0);
      cyc("rg3", 0, 0, 0,            1, 1, 64'h400200,   1, 64'h400204,   0, 0);

      // Grant withheld for four cycles: request held, buffer drains.
      cyc("gl0", 0, 0, 0,            0, 1, 64'h400204,   1, 64'h400208,   1, 64'h400200);
      cyc("gl1", 0, 0, 0,            0, 0, 0,            1, 64'h400208,   1, 64'h400204);
      cyc("gl2", 0, 0, 0,            0, 0, 0,            1, 64'h400208,   0, 0);
      cyc("gl3", 0, 0, 0,            0, 0, 0,            1, 64'h400208,   0, 0);
      cyc("gl4", 0, 0, 0,            1, 0, 0,            1, 64'h400208,   0, 0);
      cyc("gl5", 0, 0, 0,            1, 1, 64'h400208,   1, 64'h40020c,   0, 0);
      cyc("gl6", 0, 0, 0,            1, 0, 0,            1, 64'h400210,   1, 64'h400208);
      cyc("gl7", 0, 0, 0,            1, 0, 0,            0, 0,            0, 0);

      // Asynchronous reset with two requests outstanding, then restart.
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      #2;
      checkReset("midreset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc("rs0", 0, 0, 0,            1, 1, 64'h40020c,   0, 0,            0, 0);
      cyc("rs1", 0, 0, 0,            1, 0, 0,            1, A0,           0, 0);
      cyc("rs2", 0, 0, 0,            1, 1, A0,           1, A0 + 4,       0, 0);
      cyc("rs3", 0, 0, 0,            1, 1, A0 + 4,       1, A0 + 8,       1, A0);

      // Redirect to the top of the address space; pc and NPC wrap to zero.
      cyc("wr0", 0, 1, 64'hffff_ffff_ffff_fffe, 1, 1, A0 + 8, 0, 0,       1, A0 + 4);
      cyc("wr1", 0, 0, 0,            1, 1, A0 + 12,      0, 0,            0, 0);
      cyc("wr2", 0, 0, 0,            1, 0, 0,            1, 64'hffff_ffff_ffff_fffc, 0, 0);
      cyc("wr3", 0, 0, 0,            1, 1, 64'hffff_ffff_ffff_fffc, 1, 64'd0, 0, 0);
      cyc("wr4", 0, 0, 0,            1, 1, 64'd0,        1, 64'd4,        1, 64'hffff_ffff_ffff_fffc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
